// File: rtl/cursor_house_ctrl_if.sv
// Bundles the frame strobe, the raw buttons and the committed cursor/house state
// that cursor_house_ctrl exchanges with its environment.
interface cursor_house_ctrl_if;
   logic       frame_start;
   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic       G;
   logic       S;
   logic       H;
   logic       R;
   logic [9:0] cursor_x;
   logic [8:0] cursor_y;
   logic [1:0] house;
   logic       house_valid;

   modport master (
      output frame_start, up, down, left, right, G, S, H, R,
      input  cursor_x, cursor_y, house, house_valid
   );

   modport slave (
      input  frame_start, up, down, left, right, G, S, H, R,
      output cursor_x, cursor_y, house, house_valid
   );
endinterface

// File: rtl/cursor_house_ctrl.sv
// Debounced button sequencer: steps a saturating cursor and arbitrates house presses,
// committing every visible change only on the frame_start pulse.
module cursor_house_ctrl #(
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int CUR_W     = 16,
   parameter int STEP      = 4,
   parameter int DB_CYCLES = 500000
) (
   input logic clock,
   input logic reset,
   cursor_house_ctrl_if.slave bus
);
   localparam int X_MAX = H_RES - CUR_W;
   localparam int Y_MAX = V_RES - CUR_W;
   localparam int CNT_W = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, PEND, SHOW} state_t;

   // Bit order: up, down, left, right, G, S, H, R
   logic [7:0] raw;
   logic [7:0] db_level;
   assign raw = {bus.R, bus.H, bus.S, bus.G, bus.right, bus.left, bus.down, bus.up};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_btn
         logic             s1_reg;
         logic             s2_reg;
         logic             db_reg;
         logic [CNT_W-1:0] cnt_reg;

         // The level flips on the DB_CYCLES-th consecutive disagreeing sample.
         always_ff @(posedge clock) begin
            if (reset) begin
               s1_reg  <= 1'b0;
               s2_reg  <= 1'b0;
               db_reg  <= 1'b0;
               cnt_reg <= '0;
            end else begin
               s1_reg <= raw[gi];
               s2_reg <= s1_reg;
               if (s2_reg != db_reg) begin
                  if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
                     db_reg  <= s2_reg;
                     cnt_reg <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign db_level[gi] = db_reg;
      end
   endgenerate

   logic       db_up, db_down, db_left, db_right;
   assign db_up    = db_level[0];
   assign db_down  = db_level[1];
   assign db_left  = db_level[2];
   assign db_right = db_level[3];

   logic [9:0]  x_reg, x_next;
   logic [8:0]  y_reg, y_next;
   logic [10:0] x_ext, y_ext;

   // Saturation is evaluated one bit wider than the outputs so nothing wraps.
   always_comb begin
      x_ext  = {1'b0, x_reg};
      y_ext  = {2'b00, y_reg};
      x_next = x_reg;
      y_next = y_reg;
      if (db_left && !db_right)
         x_next = (x_ext >= 11'(STEP)) ? 10'(x_ext - 11'(STEP)) : '0;
      else if (db_right && !db_left)
         x_next = (x_ext + 11'(STEP) > 11'(X_MAX)) ? 10'(X_MAX) : 10'(x_ext + 11'(STEP));
      if (db_up && !db_down)
         y_next = (y_ext >= 11'(STEP)) ? 9'(y_ext - 11'(STEP)) : '0;
      else if (db_down && !db_up)
         y_next = (y_ext + 11'(STEP) > 11'(Y_MAX)) ? 9'(Y_MAX) : 9'(y_ext + 11'(STEP));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_reg <= 10'(X_MAX / 2);
         y_reg <= 9'(Y_MAX / 2);
      end else if (bus.frame_start) begin
         x_reg <= x_next;
         y_reg <= y_next;
      end
   end

   logic [3:0] house_prev_reg;
   logic [3:0] rise;
   logic       press;
   logic [1:0] press_code;

   assign rise  = db_level[7:4] & ~house_prev_reg;
   assign press = |rise;

   always_comb begin
      press_code = 2'd3;
      if (rise[0])      press_code = 2'd0;
      else if (rise[1]) press_code = 2'd1;
      else if (rise[2]) press_code = 2'd2;
   end

   state_t     state_reg;
   logic [1:0] pending_reg;
   logic [1:0] house_reg;
   logic       valid_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         house_prev_reg <= '0;
         state_reg      <= IDLE;
         pending_reg    <= '0;
         house_reg      <= '0;
         valid_reg      <= 1'b0;
      end else begin
         house_prev_reg <= db_level[7:4];
         case (state_reg)
            IDLE: begin
               if (press) begin
                  pending_reg <= press_code;
                  state_reg   <= PEND;
               end
            end
            PEND: begin
               if (press)
                  pending_reg <= press_code;
               // A press landing on the frame edge wins over the older pending value.
               if (bus.frame_start) begin
                  house_reg <= press ? press_code : pending_reg;
                  valid_reg <= 1'b1;
                  state_reg <= SHOW;
               end
            end
            SHOW: begin
               if (press) begin
                  pending_reg <= press_code;
                  state_reg   <= PEND;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.cursor_x    = x_reg;
   assign bus.cursor_y    = y_reg;
   assign bus.house       = house_reg;
   assign bus.house_valid = valid_reg;
endmodule

// File: tb/tb_cursor_house_ctrl.sv
// Directed bench for cursor_house_ctrl with a short debounce window; inputs change
// 1 time unit after a rising edge and outputs are read at the same point.
module tb_cursor_house_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   cursor_house_ctrl_if bif ();

   cursor_house_ctrl #(.DB_CYCLES(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_frame();
      bif.frame_start = 1'b1;
      tick();
      bif.frame_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      total++;
      if (bif.cursor_x !== 10'd312 || bif.cursor_y !== 9'd232) begin
         bad++;
         $display("FAIL reset_cursor: got (%0d,%0d) want (312,232)", bif.cursor_x, bif.cursor_y);
      end
      total++;
      if (bif.house_valid !== 1'b0 || bif.house !== 2'd0) begin
         bad++;
         $display("FAIL reset_house: got house=%0d valid=%0b want house=0 valid=0", bif.house, bif.house_valid);
      end
      $display("reset: cursor=(%0d,%0d) house=%0d valid=%0b", bif.cursor_x, bif.cursor_y, bif.house, bif.house_valid);
   endtask

   task automatic test_move_right();
      bif.right = 1'b1;
      idle(10);
      for (int i = 1; i <= 10; i++) begin
         total++;
         if (bif.cursor_x !== 10'(312 + 4 * (i - 1))) begin
            bad++;
            $display("FAIL right_before frame %0d: got %0d want %0d", i, bif.cursor_x, 312 + 4 * (i - 1));
         end
         pulse_frame();
         total++;
         if (bif.cursor_x !== 10'(312 + 4 * i) || bif.cursor_y !== 9'd232) begin
            bad++;
            $display("FAIL right_after frame %0d: got (%0d,%0d) want (%0d,232)", i, bif.cursor_x, bif.cursor_y, 312 + 4 * i);
         end
         $display("right frame %0d: cursor=(%0d,%0d)", i, bif.cursor_x, bif.cursor_y);
         idle(98);
      end
      bif.right = 1'b0;
      idle(10);
   endtask

   task automatic test_glitch();
      bif.up = 1'b1;
      idle(3);
      bif.up = 1'b0;
      for (int i = 0; i < 5; i++) begin
         idle(20);
         pulse_frame();
         total++;
         if (bif.cursor_y !== 9'd232 || bif.cursor_x !== 10'd352) begin
            bad++;
            $display("FAIL glitch frame %0d: got (%0d,%0d) want (352,232)", i, bif.cursor_x, bif.cursor_y);
         end
         $display("glitch frame %0d: cursor=(%0d,%0d)", i, bif.cursor_x, bif.cursor_y);
      end
      bif.up   = 1'b1;
      bif.down = 1'b1;
      idle(10);
      for (int i = 0; i < 3; i++) begin
         pulse_frame();
         total++;
         if (bif.cursor_y !== 9'd232) begin
            bad++;
            $display("FAIL up_down frame %0d: got y=%0d want 232", i, bif.cursor_y);
         end
         $display("up+down frame %0d: cursor=(%0d,%0d)", i, bif.cursor_x, bif.cursor_y);
         idle(5);
      end
      bif.up   = 1'b0;
      bif.down = 1'b0;
      idle(10);
   endtask

   task automatic test_saturate();
      int ex = 352;
      int ey = 232;
      bif.left = 1'b1;
      bif.up   = 1'b1;
      idle(10);
      for (int f = 1; f <= 90; f++) begin
         pulse_frame();
         ex = (ex >= 4) ? ex - 4 : 0;
         ey = (ey >= 4) ? ey - 4 : 0;
         total++;
         if (bif.cursor_x !== 10'(ex) || bif.cursor_y !== 9'(ey)) begin
            bad++;
            $display("FAIL sat_low frame %0d: got (%0d,%0d) want (%0d,%0d)", f, bif.cursor_x, bif.cursor_y, ex, ey);
         end
         $display("up-left frame %0d: cursor=(%0d,%0d)", f, bif.cursor_x, bif.cursor_y);
      end
      bif.left  = 1'b0;
      bif.up    = 1'b0;
      bif.right = 1'b1;
      bif.down  = 1'b1;
      idle(10);
      for (int f = 1; f <= 160; f++) begin
         pulse_frame();
         ex = (ex + 4 > 624) ? 624 : ex + 4;
         ey = (ey + 4 > 464) ? 464 : ey + 4;
         total++;
         if (bif.cursor_x !== 10'(ex) || bif.cursor_y !== 9'(ey)) begin
            bad++;
            $display("FAIL sat_high frame %0d: got (%0d,%0d) want (%0d,%0d)", f, bif.cursor_x, bif.cursor_y, ex, ey);
         end
         $display("down-right frame %0d: cursor=(%0d,%0d)", f, bif.cursor_x, bif.cursor_y);
      end
      bif.right = 1'b0;
      bif.down  = 1'b0;
      idle(10);
   endtask

   task automatic test_house();
      bif.S = 1'b1;
      bif.H = 1'b1;
      idle(10);
      total++;
      if (bif.house_valid !== 1'b0) begin
         bad++;
         $display("FAIL house_early_valid: got %0b want 0", bif.house_valid);
      end
      pulse_frame();
      total++;
      if (bif.house !== 2'd1 || bif.house_valid !== 1'b1) begin
         bad++;
         $display("FAIL house_s_over_h: got house=%0d valid=%0b want house=1 valid=1", bif.house, bif.house_valid);
      end
      $display("S+H commit: house=%0d valid=%0b", bif.house, bif.house_valid);

      bif.R = 1'b1;
      idle(10);
      total++;
      if (bif.house !== 2'd1 || bif.house_valid !== 1'b1) begin
         bad++;
         $display("FAIL house_hold_old: got house=%0d valid=%0b want house=1 valid=1", bif.house, bif.house_valid);
      end
      pulse_frame();
      total++;
      if (bif.house !== 2'd3) begin
         bad++;
         $display("FAIL house_r: got %0d want 3", bif.house);
      end
      $display("R commit: house=%0d valid=%0b", bif.house, bif.house_valid);

      bif.S = 1'b0;
      bif.H = 1'b0;
      bif.R = 1'b0;
      idle(10);
      pulse_frame();
      total++;
      if (bif.house !== 2'd3 || bif.house_valid !== 1'b1) begin
         bad++;
         $display("FAIL house_release: got house=%0d valid=%0b want house=3 valid=1", bif.house, bif.house_valid);
      end

      // S goes pending, then G's debounced edge lands exactly on the frame pulse.
      bif.S = 1'b1;
      idle(10);
      bif.G = 1'b1;
      idle(6);
      pulse_frame();
      total++;
      if (bif.house !== 2'd0 || bif.house_valid !== 1'b1) begin
         bad++;
         $display("FAIL house_coincide: got house=%0d valid=%0b want house=0 valid=1", bif.house, bif.house_valid);
      end
      $display("G on frame edge: house=%0d valid=%0b", bif.house, bif.house_valid);
      bif.S = 1'b0;
      bif.G = 1'b0;
      idle(10);
   endtask

   task automatic test_reset_mid();
      bif.down = 1'b1;
      idle(10);
      pulse_frame();
      idle(50);
      pulse_frame();
      idle(30);
      total++;
      if (bif.cursor_y !== 9'd464) begin
         bad++;
         $display("FAIL pre_reset_y: got %0d want 464", bif.cursor_y);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if (bif.cursor_x !== 10'd312 || bif.cursor_y !== 9'd232 || bif.house_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got (%0d,%0d) valid=%0b want (312,232) valid=0", bif.cursor_x, bif.cursor_y, bif.house_valid);
      end
      $display("mid reset: cursor=(%0d,%0d) valid=%0b", bif.cursor_x, bif.cursor_y, bif.house_valid);
      idle(5);
      pulse_frame();
      total++;
      if (bif.cursor_y !== 9'd232) begin
         bad++;
         $display("FAIL db_not_ready: got y=%0d want 232", bif.cursor_y);
      end
      pulse_frame();
      total++;
      if (bif.cursor_y !== 9'd236) begin
         bad++;
         $display("FAIL first_move: got y=%0d want 236", bif.cursor_y);
      end
      $display("after reset down: cursor=(%0d,%0d)", bif.cursor_x, bif.cursor_y);
      bif.down = 1'b0;
      idle(10);
   endtask

   initial begin
      bif.frame_start = 1'b0;
      bif.up = 1'b0;  bif.down = 1'b0;  bif.left = 1'b0;  bif.right = 1'b0;
      bif.G = 1'b0;   bif.S = 1'b0;     bif.H = 1'b0;     bif.R = 1'b0;
      #1;
      test_reset();
      test_move_right();
      test_glitch();
      test_saturate();
      test_house();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
